// File: rtl/log2_pkg.sv
// Shared helpers for the streaming log2 unit: result-width derivation,
// leading-one search and the elaboration-time fraction table generator.
package log2_pkg;

   // Fixed-point precision used while generating the fraction table.
   localparam int LUT_PREC  = 30;
   localparam int LUT_GUARD = 6;

   function automatic int calc_int_w(input int din_w);
      return $clog2(din_w) + 1;
   endfunction

   function automatic int calc_dout_w(input int din_w, input int frac_out);
      return calc_int_w(din_w) + frac_out;
   endfunction

   function automatic int calc_idx_w(input int din_w);
      return (din_w > 1) ? $clog2(din_w) : 1;
   endfunction

   // Highest set bit of v; returns 0 for v==0, so callers must flag zero separately.
   function automatic int lead_one_index(input logic [63:0] v);
      int idx;
      idx = 0;
      for (int k = 0; k < 64; k++) begin
         if (v[k]) idx = k;
      end
      return idx;
   endfunction

   // round(log2(1 + k/2^addr_w) * 2^frac_w), saturated to the fraction range.
   function automatic int lut_entry(input int k, input int addr_w, input int frac_w);
      logic [63:0] x;
      logic [63:0] two;
      int          bits;
      int          r;
      int          lim;
      two  = 64'd2 << LUT_PREC;
      x    = (64'd1 << LUT_PREC) + ((64'(k) << LUT_PREC) >> addr_w);
      bits = 0;
      // Each squaring of the mantissa in [1,2) yields the next log2 fraction bit.
      for (int n = 0; n < frac_w + LUT_GUARD; n++) begin
         x    = (x * x) >> LUT_PREC;
         bits = bits * 2;
         if (x >= two) begin
            bits = bits + 1;
            x    = x >> 1;
         end
      end
      r   = (bits + (1 << (LUT_GUARD - 1))) >> LUT_GUARD;
      lim = (1 << frac_w) - 1;
      return (r > lim) ? lim : r;
   endfunction

endpackage

// File: rtl/log2_lod.sv
// Combinational leading-one detector: index of the highest set bit plus a
// zero flag for an all-zero vector. Supports widths up to 64 bits.
module log2_lod
   import log2_pkg::*;
#(
   parameter int W  = 24,
   parameter int PW = calc_idx_w(W)
) (
   input  logic [W-1:0]  vec,
   output logic [PW-1:0] idx,
   output logic          zero
);

   always_comb begin
      idx  = PW'(lead_one_index(64'(vec)));
      zero = (vec == '0);
   end

endmodule

// File: rtl/log2_stream.sv
// Pipelined fixed-point log2 with valid/ready on both sides: leading-one
// detect, normalise to a table address, then table lookup into {int, frac}.
module log2_stream
   import log2_pkg::*;
#(
   parameter int  DIN_W    = 24,
   parameter int  FRAC_IN  = 8,
   parameter int  LUT_ADDR = 6,
   parameter int  FRAC_OUT = 8,
   localparam int INT_W    = calc_int_w(DIN_W),
   localparam int DOUT_W   = calc_dout_w(DIN_W, FRAC_OUT)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DIN_W-1:0]  din,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DOUT_W-1:0] dout,
   output logic              out_zero
);

   localparam int                IDX_W     = calc_idx_w(DIN_W);
   localparam int                LUT_SIZE  = 1 << LUT_ADDR;
   localparam logic [DOUT_W-1:0] ZERO_CODE = DOUT_W'(1) << (DOUT_W - 1);

   logic                        advance;

   logic                        s1_valid_q, s1_valid_d;
   logic [DIN_W-1:0]            s1_din_q,   s1_din_d;
   logic [IDX_W-1:0]            s1_idx_q,   s1_idx_d;
   logic                        s1_zero_q,  s1_zero_d;

   logic                        s2_valid_q, s2_valid_d;
   logic [LUT_ADDR-1:0]         s2_addr_q,  s2_addr_d;
   logic [INT_W-1:0]            s2_int_q,   s2_int_d;
   logic                        s2_zero_q,  s2_zero_d;

   logic                        out_valid_q, out_valid_d;
   logic [DOUT_W-1:0]           dout_q,      dout_d;
   logic                        out_zero_q,  out_zero_d;

   logic [IDX_W-1:0]            lod_idx;
   logic                        lod_zero;
   logic [DIN_W+LUT_ADDR-1:0]   norm_ext;
   logic [LUT_ADDR-1:0]         norm_addr;
   logic [INT_W-1:0]            norm_int;

   logic [FRAC_OUT-1:0]         lut_rom [LUT_SIZE];

   // Fraction table is a constant ROM built at elaboration.
   for (genvar gi = 0; gi < LUT_SIZE; gi++) begin : g_lut
      localparam int ENTRY = lut_entry(gi, LUT_ADDR, FRAC_OUT);
      assign lut_rom[gi] = FRAC_OUT'(ENTRY);
   end

   log2_lod #(
      .W  (DIN_W),
      .PW (IDX_W)
   ) u_lod (
      .vec  (din),
      .idx  (lod_idx),
      .zero (lod_zero)
   );

   always_comb begin
      advance  = !out_valid_q || out_ready;
      in_ready = advance;

      // Shifting the zero-padded operand right by p leaves the LUT_ADDR bits
      // just below the leading one at the bottom; short operands get zero fill.
      norm_ext  = {s1_din_q, {LUT_ADDR{1'b0}}};
      norm_addr = LUT_ADDR'(norm_ext >> s1_idx_q);
      norm_int  = INT_W'(int'(s1_idx_q) - FRAC_IN);

      s1_valid_d  = s1_valid_q;
      s1_din_d    = s1_din_q;
      s1_idx_d    = s1_idx_q;
      s1_zero_d   = s1_zero_q;
      s2_valid_d  = s2_valid_q;
      s2_addr_d   = s2_addr_q;
      s2_int_d    = s2_int_q;
      s2_zero_d   = s2_zero_q;
      out_valid_d = out_valid_q;
      dout_d      = dout_q;
      out_zero_d  = out_zero_q;

      if (advance) begin
         s1_valid_d  = in_valid;
         s1_din_d    = din;
         s1_idx_d    = lod_idx;
         s1_zero_d   = lod_zero;

         s2_valid_d  = s1_valid_q;
         s2_addr_d   = norm_addr;
         s2_int_d    = norm_int;
         s2_zero_d   = s1_zero_q;

         out_valid_d = s2_valid_q;
         out_zero_d  = s2_valid_q && s2_zero_q;
         dout_d      = s2_zero_q ? ZERO_CODE : {s2_int_q, lut_rom[s2_addr_q]};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid_q  <= 1'b0;
         s1_din_q    <= '0;
         s1_idx_q    <= '0;
         s1_zero_q   <= 1'b0;
         s2_valid_q  <= 1'b0;
         s2_addr_q   <= '0;
         s2_int_q    <= '0;
         s2_zero_q   <= 1'b0;
         out_valid_q <= 1'b0;
         dout_q      <= '0;
         out_zero_q  <= 1'b0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_din_q    <= s1_din_d;
         s1_idx_q    <= s1_idx_d;
         s1_zero_q   <= s1_zero_d;
         s2_valid_q  <= s2_valid_d;
         s2_addr_q   <= s2_addr_d;
         s2_int_q    <= s2_int_d;
         s2_zero_q   <= s2_zero_d;
         out_valid_q <= out_valid_d;
         dout_q      <= dout_d;
         out_zero_q  <= out_zero_d;
      end
   end

   assign out_valid = out_valid_q;
   assign dout      = dout_q;
   assign out_zero  = out_zero_q;

endmodule

// File: tb/tb_log2_stream.sv
// Directed and randomised checks of log2_stream at the default configuration
// and at a narrow 16-bit / integer-input configuration.
module tb_log2_stream;

   localparam int A_DIN_W    = 24;
   localparam int A_FRAC_IN  = 8;
   localparam int A_LUT_ADDR = 6;
   localparam int A_FRAC_OUT = 8;
   localparam int A_DOUT_W   = 14;

   localparam int B_DIN_W    = 16;
   localparam int B_FRAC_IN  = 0;
   localparam int B_LUT_ADDR = 5;
   localparam int B_FRAC_OUT = 4;
   localparam int B_DOUT_W   = 9;

   logic                  clk = 1'b0;
   logic                  rst;
   logic                  in_valid, in_ready, out_valid, out_ready, out_zero;
   logic [A_DIN_W-1:0]    din;
   logic [A_DOUT_W-1:0]   dout;
   logic                  b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_zero;
   logic [B_DIN_W-1:0]    b_din;
   logic [B_DOUT_W-1:0]   b_dout;

   int n_cmp;
   int n_bad;

   always #5 clk = ~clk;

   log2_stream #(
      .DIN_W(A_DIN_W), .FRAC_IN(A_FRAC_IN), .LUT_ADDR(A_LUT_ADDR), .FRAC_OUT(A_FRAC_OUT)
   ) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .din(din),
      .out_valid(out_valid), .out_ready(out_ready), .dout(dout), .out_zero(out_zero)
   );

   log2_stream #(
      .DIN_W(B_DIN_W), .FRAC_IN(B_FRAC_IN), .LUT_ADDR(B_LUT_ADDR), .FRAC_OUT(B_FRAC_OUT)
   ) u_dut_b (
      .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .din(b_din),
      .out_valid(b_out_valid), .out_ready(b_out_ready), .dout(b_dout), .out_zero(b_out_zero)
   );

   // Reference: floor log2 index, truncated mantissa address, rounded log2 fraction.
   function automatic int gold_dout(input longint unsigned x, input int fi, input int la,
                                    input int fo, input int dw);
      longint unsigned a_full;
      int              p, a, i, f;
      real             r;
      if (x == 0) return 1 << (dw - 1);
      p = 0;
      while ((x >> (p + 1)) != 0) p++;
      a_full = (x << la) >> p;
      a      = int'(a_full) - (1 << la);
      i      = p - fi;
      r      = $ln(1.0 + real'(a) / real'(1 << la)) / $ln(2.0) * real'(1 << fo);
      f      = $rtoi(r + 0.5);
      if (f > (1 << fo) - 1) f = (1 << fo) - 1;
      return (i * (1 << fo) + f) & ((1 << dw) - 1);
   endfunction

   function automatic logic [A_DIN_W-1:0] rand_din_a();
      logic [A_DIN_W-1:0] one;
      one = 1;
      case ($urandom_range(0, 3))
         0:       return A_DIN_W'($urandom);
         1:       return A_DIN_W'($urandom_range(0, 511));
         2:       return '0;
         default: return (one << $urandom_range(0, A_DIN_W - 1)) | A_DIN_W'($urandom_range(0, 3));
      endcase
   endfunction

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; din = '0;
      b_in_valid = 1'b0; b_out_ready = 1'b1; b_din = '0;
      repeat (2) @(posedge clk);
      #1;
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid: got %b required 0", out_valid); end
      n_cmp++; if (out_zero !== 1'b0) begin n_bad++; $display("FAIL rst_out_zero: got %b required 0", out_zero); end
      n_cmp++; if (dout !== 14'h0000) begin n_bad++; $display("FAIL rst_dout: got %h required 0000", dout); end
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_in_ready: got %b required 1", in_ready); end
      n_cmp++; if (b_out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_b_out_valid: got %b required 0", b_out_valid); end
      $display("reset: out_valid=%b in_ready=%b dout=%h", out_valid, in_ready, dout);
      rst = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_latency();
      din = 24'h000100; in_valid = 1'b1; out_ready = 1'b1;
      #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL lat_in_ready: got %b required 1", in_ready); end
      @(posedge clk); #1;
      in_valid = 1'b0;
      for (int c = 1; c <= 3; c++) begin
         n_cmp++;
         if (out_valid !== (c == 3)) begin
            n_bad++; $display("FAIL lat_cycle%0d: got out_valid=%b required %b", c, out_valid, (c == 3));
         end
         if (c < 3) begin @(posedge clk); #1; end
      end
      n_cmp++; if (dout !== 14'h0000) begin n_bad++; $display("FAIL lat_dout: got %h required 0000", dout); end
      n_cmp++; if (out_zero !== 1'b0) begin n_bad++; $display("FAIL lat_zero: got %b required 0", out_zero); end
      $display("latency: din=000100 dout=%h zero=%b", dout, out_zero);
      @(posedge clk); #1;
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL lat_drain: got out_valid=%b required 0", out_valid); end
   endtask

   task automatic test_values();
      logic [A_DIN_W-1:0]  vin  [7] = '{24'h000200, 24'h000080, 24'h000180, 24'hFFFFFF,
                                        24'h000000, 24'h000001, 24'h000003};
      logic [A_DOUT_W-1:0] vexp [7] = '{14'h0100, 14'h3F00, 14'h0096, 14'h0FFD,
                                        14'h2000, 14'h3800, 14'h3996};
      logic                vz   [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      logic                got;
      out_ready = 1'b1;
      for (int v = 0; v < 7; v++) begin
         din = vin[v]; in_valid = 1'b1;
         @(posedge clk); #1;
         in_valid = 1'b0;
         got = 1'b0;
         for (int c = 0; c < 10 && !got; c++) begin
            if (out_valid) got = 1'b1;
            else begin @(posedge clk); #1; end
         end
         n_cmp++;
         if (!got) begin
            n_bad++; $display("FAIL val%0d_timeout: got no out_valid required a result", v);
         end else begin
            if (dout !== vexp[v] || out_zero !== vz[v]) begin
               n_bad++;
               $display("FAIL val%0d: got dout=%h zero=%b required dout=%h zero=%b",
                        v, dout, out_zero, vexp[v], vz[v]);
            end
            $display("value: din=%h dout=%h zero=%b", vin[v], dout, out_zero);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_back_to_back();
      logic [A_DIN_W-1:0]  vin  [3] = '{24'h000100, 24'h000200, 24'h000400};
      logic [A_DOUT_W-1:0] vexp [3] = '{14'h0000, 14'h0100, 14'h0200};
      out_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         din = vin[k]; in_valid = 1'b1;
         #1;
         n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_in_ready%0d: got %b required 1", k, in_ready); end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         n_cmp++;
         if (out_valid !== 1'b1 || dout !== vexp[k]) begin
            n_bad++; $display("FAIL b2b_out%0d: got valid=%b dout=%h required valid=1 dout=%h", k, out_valid, dout, vexp[k]);
         end
         $display("b2b: result %0d dout=%h", k, dout);
         @(posedge clk); #1;
      end
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_tail: got out_valid=%b required 0", out_valid); end
   endtask

   task automatic test_backpressure();
      logic [A_DIN_W-1:0]  vin  [5] = '{24'h000100, 24'h000200, 24'h000400, 24'h000800, 24'h001000};
      logic [A_DOUT_W-1:0] vexp [5] = '{14'h0000, 14'h0100, 14'h0200, 14'h0300, 14'h0400};
      logic [A_DOUT_W-1:0] held;
      logic                holding;
      int                  ip, op, stalls;
      ip = 0; op = 0; stalls = 0; holding = 1'b0; held = '0;
      for (int cyc = 0; cyc < 40 && op < 5; cyc++) begin
         out_ready = !(cyc >= 4 && cyc < 9);
         in_valid  = (ip < 5);
         din       = (ip < 5) ? vin[ip] : 24'h0;
         #1;
         if (out_valid && !out_ready) begin
            n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready: got %b required 0", in_ready); end
            if (holding) begin
               n_cmp++; if (dout !== held) begin n_bad++; $display("FAIL bp_hold: got %h required %h", dout, held); end
            end
            held = dout; holding = 1'b1; stalls++;
         end else begin
            holding = 1'b0;
         end
         if (out_valid && out_ready) begin
            n_cmp++;
            if (dout !== vexp[op] || out_zero !== 1'b0) begin
               n_bad++; $display("FAIL bp_out%0d: got dout=%h zero=%b required dout=%h zero=0", op, dout, out_zero, vexp[op]);
            end
            $display("bp: result %0d dout=%h", op, dout);
            op++;
         end
         if (in_valid && in_ready) ip++;
         @(posedge clk); #1;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      n_cmp++; if (op != 5) begin n_bad++; $display("FAIL bp_count: got %0d results required 5", op); end
      n_cmp++; if (stalls != 5) begin n_bad++; $display("FAIL bp_stalls: got %0d stalled cycles required 5", stalls); end
      for (int c = 0; c < 5; c++) begin
         n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_dup: got out_valid=%b dout=%h required 0", out_valid, dout); end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset_flight();
      logic [A_DIN_W-1:0]  vin [3] = '{24'h000100, 24'h000200, 24'h000400};
      logic [A_DOUT_W-1:0] first;
      int                  seen;
      out_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         din = vin[k]; in_valid = 1'b1;
         @(posedge clk); #1;
      end
      in_valid = 1'b0; din = '0;
      #2; rst = 1'b1; #1;
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rf_out_valid: got %b required 0", out_valid); end
      n_cmp++; if (dout !== 14'h0000) begin n_bad++; $display("FAIL rf_dout: got %h required 0000", dout); end
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rf_in_ready: got %b required 1", in_ready); end
      @(posedge clk); #1;
      rst = 1'b0;
      din = 24'h000800; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      seen = 0; first = '0;
      for (int c = 0; c < 10; c++) begin
         if (out_valid) begin
            if (seen == 0) first = dout;
            seen++;
         end
         @(posedge clk); #1;
      end
      n_cmp++; if (seen != 1) begin n_bad++; $display("FAIL rf_count: got %0d results required 1", seen); end
      n_cmp++; if (first !== 14'h0300) begin n_bad++; $display("FAIL rf_dout_new: got %h required 0300", first); end
      $display("reset-flight: results=%0d first=%h", seen, first);
   endtask

   task automatic test_random();
      logic [A_DOUT_W-1:0] qa_d [$];
      logic                qa_z [$];
      logic [B_DOUT_W-1:0] qb_d [$];
      logic                qb_z [$];
      logic [A_DOUT_W-1:0] ea;
      logic [B_DOUT_W-1:0] eb;
      logic                ez;
      for (int cyc = 0; cyc < 700; cyc++) begin
         if (cyc < 600) begin
            in_valid    = ($urandom_range(0, 3) != 0);
            out_ready   = ($urandom_range(0, 3) != 0);
            din         = rand_din_a();
            b_in_valid  = ($urandom_range(0, 2) != 0);
            b_out_ready = ($urandom_range(0, 2) != 0);
            b_din       = B_DIN_W'($urandom >> $urandom_range(0, 15));
         end else begin
            in_valid = 1'b0; out_ready = 1'b1; b_in_valid = 1'b0; b_out_ready = 1'b1;
         end
         #1;
         if (out_valid && out_ready) begin
            n_cmp++;
            if (qa_d.size() == 0) begin
               n_bad++; $display("FAIL rand_a_extra: got dout=%h required no result", dout);
            end else begin
               ea = qa_d.pop_front(); ez = qa_z.pop_front();
               if (dout !== ea || out_zero !== ez) begin
                  n_bad++; $display("FAIL rand_a: got dout=%h zero=%b required dout=%h zero=%b", dout, out_zero, ea, ez);
               end
               $display("rand A: dout=%h zero=%b", dout, out_zero);
            end
         end
         if (b_out_valid && b_out_ready) begin
            n_cmp++;
            if (qb_d.size() == 0) begin
               n_bad++; $display("FAIL rand_b_extra: got dout=%h required no result", b_dout);
            end else begin
               eb = qb_d.pop_front(); ez = qb_z.pop_front();
               if (b_dout !== eb || b_out_zero !== ez) begin
                  n_bad++; $display("FAIL rand_b: got dout=%h zero=%b required dout=%h zero=%b", b_dout, b_out_zero, eb, ez);
               end
               $display("rand B: dout=%h zero=%b", b_dout, b_out_zero);
            end
         end
         if (in_valid && in_ready) begin
            qa_d.push_back(A_DOUT_W'(gold_dout(din, A_FRAC_IN, A_LUT_ADDR, A_FRAC_OUT, A_DOUT_W)));
            qa_z.push_back(din == '0);
         end
         if (b_in_valid && b_in_ready) begin
            qb_d.push_back(B_DOUT_W'(gold_dout(b_din, B_FRAC_IN, B_LUT_ADDR, B_FRAC_OUT, B_DOUT_W)));
            qb_z.push_back(b_din == '0);
         end
         @(posedge clk); #1;
      end
      n_cmp++; if (qa_d.size() != 0) begin n_bad++; $display("FAIL rand_a_lost: got %0d pending required 0", qa_d.size()); end
      n_cmp++; if (qb_d.size() != 0) begin n_bad++; $display("FAIL rand_b_lost: got %0d pending required 0", qb_d.size()); end
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      test_reset();
      test_latency();
      test_values();
      test_back_to_back();
      test_backpressure();
      test_reset_flight();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/log2_stream.md
# log2_stream

Parametrised, pipelined base-2 logarithm with valid/ready handshakes on both sides. It accepts an unsigned fixed-point operand and returns a signed fixed-point log2 result. It is the next generation of the team's fixed-width log2 units:
- configurable input width, binary-point position, LUT depth and output fraction width;
- inputs below 1.0 handled as negative logs, zero input flagged;
- full backpressure support.

It sits between streaming sample sources (ADC/power detectors) and dB-scaling or AGC logic.

## Interface
- DIN_W, 24: input operand width, unsigned.
- FRAC_IN, 8: input fraction bits (binary point sits between bit FRAC_IN and bit FRAC_IN-1); range 0..DIN_W-1.
- LUT_ADDR, 6: mantissa bits used to index the fraction LUT (2^LUT_ADDR entries).
- FRAC_OUT, 8: output fraction bits.
- Derived INT_W = $clog2(DIN_W)+1: signed integer bits of the result. Derived DOUT_W = INT_W+FRAC_OUT.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand valid.
- in_ready  out  1  block accepts operand this cycle.
- din  in  DIN_W  unsigned operand.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- dout  out  DOUT_W  signed two's-complement log2(din / 2^FRAC_IN), FRAC_OUT fraction bits.
- out_zero  out  1  result belongs to a din==0 operand.

## Operation
- Transfer in: the operand is taken when in_valid && in_ready. Transfer out: the result is taken when out_valid && out_ready.
- Global-stall pipeline, 3 stages, with advance = !out_valid || out_ready. The in_ready output equals advance. All stage registers and stage valids update only when advance=1.
- S1: register din and detect the leading-one index p (0..DIN_W-1). Set zero flag if din==0.
- S2, normalise: take the LUT_ADDR bits immediately below bit p as address a.
  - If p < LUT_ADDR, zero-pad the missing low bits.
  - Truncate, never round.
  - Integer part is i = p - FRAC_IN, signed INT_W.
- S3: f = LUT[a]. The result is dout = {i, f}.
  - For a zero operand: dout = most-negative value (MSB=1, rest 0) and out_zero=1.
  - Otherwise out_zero=0.
- LUT[k] = round(log2(1 + k/2^LUT_ADDR) * 2^FRAC_OUT), clipped to 2^FRAC_OUT-1. LUT[0]=0.
- The result is monotonic non-decreasing in din for din>0.
- No operand is dropped or duplicated. Bubbles (in_valid=0) propagate as invalid stages.

## Timing
- Reset values: out_valid=0, out_zero=0, dout=0, all internal stage valids 0. in_ready=1 during and after reset, since it follows out_valid=0.
- Latency: with out_ready held high, a result appears exactly 3 cycles after acceptance. Throughput is 1 per cycle.
- Backpressure: while out_valid=1 and out_ready=0:
  - dout, out_zero and out_valid hold stable;
  - in_ready=0;
  - no stage advances.
- Simultaneous transfer in and transfer out in one cycle is legal and required for full throughput.
- Reset mid-operation: all in-flight operands are discarded immediately (asynchronous). The first result after reset release comes from an operand accepted after release.
- in_ready is combinational from out_ready and out_valid. It has no path from in_valid.

## Structure
- Package log2_pkg holds:
  - the INT_W/DOUT_W derivation functions;
  - a constant function generating the LUT from LUT_ADDR/FRAC_OUT, elaborated at compile time, not a data file;
  - the leading-one-index function.
- One sub-module, log2_lod: parametrised combinational leading-one detector (index plus zero flag), used by S1.
- Top-level log2_stream owns the handshake, stage registers, normaliser and LUT.

## Test plan
Defaults apply throughout (dout 14 bits, out_ready=1 unless stated).
- din=0x000100 -> dout=0x0000, out_zero=0, out_valid exactly 3 cycles after acceptance.
- din=0x000200 -> 0x0100; din=0x000080 -> 0x3F00 (-1.0); din=0x000180 -> 0x0096 (LUT[32]=150).
- din=0xFFFFFF -> 0x0FFD (15 + 253/256). din=0x000000 -> dout=0x2000, out_zero=1.
- Back-to-back operands 0x000100, 0x000200, 0x000400, one per cycle -> 0x0000, 0x0100, 0x0200 on consecutive cycles.
  - Then drop out_ready for 5 cycles: dout holds, in_ready=0, no loss. On release, the remaining results follow in order.
- Assert rst with 3 operands in flight -> out_valid=0 immediately. After release, a new operand 0x000800 -> 0x0300 with no stale results.
- Random din with random in_valid/out_ready against a golden model (floor-index, truncated address, LUT formula). Repeat with DIN_W=16, FRAC_IN=0, LUT_ADDR=5, FRAC_OUT=4.
